io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller_if.sv | 26 ++
 rtl/io_controller.sv | 114 +++++++++++
 tb/tb_io_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// Bus bundle for io_controller: CPU-side load/store port, retire pulse and the
// UART transmit/receive handshakes.
interface io_controller_if;
  logic [7:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        instr_retire;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output io_addr, io_we, io_re, io_wdata, instr_retire, tx_ready, rx_data, rx_valid,
    input  io_rdata, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  io_addr, io_we, io_re, io_wdata, instr_retire, tx_ready, rx_data, rx_valid,
    output io_rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped IO block: one-entry UART TX/RX buffers, cycle and retired
// instruction counters, and a registered (M-stage) read port.
module io_controller #(
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  io_controller_if.slave  bus
);

  typedef enum logic { TX_EMPTY, TX_FULL } tx_state_e;
  typedef enum logic { RX_EMPTY, RX_FULL } rx_state_e;

  localparam logic [5:0] W_TX_CTRL   = 6'd0;
  localparam logic [5:0] W_RX_CTRL   = 6'd1;
  localparam logic [5:0] W_TX_DATA   = 6'd2;
  localparam logic [5:0] W_RX_DATA   = 6'd3;
  localparam logic [5:0] W_CYCLE_CNT = 6'd4;
  localparam logic [5:0] W_INSTR_CNT = 6'd5;
  localparam logic [5:0] W_CNT_RST   = 6'd6;

  tx_state_e          tx_state_q, tx_state_d;
  rx_state_e          rx_state_q, rx_state_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [7:0]         rx_byte_q, rx_byte_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ins_q, ins_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        rd_word;

  logic [5:0] word;
  logic       wr_tx, wr_cnt_rst, rd_rx_pop;
  logic       unused_bits;

  assign word        = bus.io_addr[7:2];
  assign wr_tx       = bus.io_we && (word == W_TX_DATA);
  assign wr_cnt_rst  = bus.io_we && (word == W_CNT_RST);
  assign rd_rx_pop   = bus.io_re && (word == W_RX_DATA);
  assign unused_bits = ^{bus.io_addr[1:0], bus.io_wdata[31:8]};

  // Read mux always reflects pre-update state so a same-cycle write cannot leak in.
  always_comb begin
    rd_word = '0;
    case (word)
      W_TX_CTRL:   rd_word = {31'd0, tx_state_q == TX_EMPTY};
      W_RX_CTRL:   rd_word = {31'd0, rx_state_q == RX_FULL};
      W_RX_DATA:   rd_word = {24'd0, rx_byte_q};
      W_CYCLE_CNT: rd_word = 32'(cyc_q);
      W_INSTR_CNT: rd_word = 32'(ins_q);
      default:     rd_word = '0;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    rx_state_d = rx_state_q;
    rx_byte_d  = rx_byte_q;
    rdata_d    = bus.io_re ? rd_word : rdata_q;

    // A write landing while full (even on the handshake edge) is dropped.
    if (tx_state_q == TX_EMPTY) begin
      if (wr_tx) begin
        tx_state_d = TX_FULL;
        tx_byte_d  = bus.io_wdata[7:0];
      end
    end else if (bus.tx_ready) begin
      tx_state_d = TX_EMPTY;
    end

    if (rx_state_q == RX_EMPTY) begin
      if (bus.rx_valid) begin
        rx_state_d = RX_FULL;
        rx_byte_d  = bus.rx_data;
      end
    end else if (rd_rx_pop) begin
      rx_state_d = RX_EMPTY;
    end

    if (wr_cnt_rst) begin
      cyc_d = '0;
      ins_d = '0;
    end else begin
      cyc_d = cyc_q + CNT_W'(1);
      ins_d = ins_q + CNT_W'(bus.instr_retire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_EMPTY;
      rx_state_q <= RX_EMPTY;
      tx_byte_q  <= '0;
      rx_byte_q  <= '0;
      cyc_q      <= '0;
      ins_q      <= '0;
      rdata_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      tx_byte_q  <= tx_byte_d;
      rx_byte_q  <= rx_byte_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.io_rdata = rdata_q;
  assign bus.tx_valid = (tx_state_q == TX_FULL);
  assign bus.tx_data  = tx_byte_q;
  assign bus.rx_ready = (rx_state_q == RX_EMPTY);

endmodule

// File: tb/tb_io_controller.sv
// Bench for io_controller: directed vector table, hand-written counter/reset/wrap
// sequences and a randomized run against a behavioural model.
module tb_io_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_controller_if bus();
  io_controller_if bus4();

  io_controller #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  io_controller #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks = 0;
  int errors = 0;

  // Behavioural model state for the 32-bit instance.
  bit          m_tx_full, m_rx_full;
  logic [7:0]  m_tx_byte, m_rx_byte;
  longint      m_cyc, m_ins;
  logic [31:0] m_rdata;

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic        txr;
    logic        rxv;
    logic [7:0]  rxd;
    logic [31:0] e_rdata;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_rxr;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [7:0] a, input logic we, input logic re,
                            input logic [31:0] wd, input logic ret, input logic txr,
                            input logic rxv, input logic [7:0] rxd);
    logic [31:0] rv;
    int off;
    if (r) begin
      m_tx_full = 0; m_rx_full = 0; m_tx_byte = 0; m_rx_byte = 0;
      m_cyc = 0; m_ins = 0; m_rdata = 0;
      return;
    end
    off = int'(a) & 'hFC;
    case (off)
      'h00: rv = m_tx_full ? 32'd0 : 32'd1;
      'h04: rv = m_rx_full ? 32'd1 : 32'd0;
      'h0C: rv = {24'd0, m_rx_byte};
      'h10: rv = 32'(m_cyc);
      'h14: rv = 32'(m_ins);
      default: rv = 32'd0;
    endcase
    if (re) m_rdata = rv;
    if (m_tx_full) begin
      if (txr) m_tx_full = 0;
    end else if (we && off == 'h08) begin
      m_tx_full = 1; m_tx_byte = wd[7:0];
    end
    if (m_rx_full) begin
      if (re && off == 'h0C) m_rx_full = 0;
    end else if (rxv) begin
      m_rx_full = 1; m_rx_byte = rxd;
    end
    if (we && off == 'h18) begin
      m_cyc = 0; m_ins = 0;
    end else begin
      m_cyc = (m_cyc + 1) % 64'h1_0000_0000;
      m_ins = (m_ins + (ret ? 1 : 0)) % 64'h1_0000_0000;
    end
  endtask

  task automatic step(input logic [7:0] a, input logic we, input logic re, input logic [31:0] wd,
                      input logic ret, input logic txr, input logic rxv, input logic [7:0] rxd);
    bus.io_addr = a; bus.io_we = we; bus.io_re = re; bus.io_wdata = wd;
    bus.instr_retire = ret; bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
    @(posedge clk);
    model_edge(rst, a, we, re, wd, ret, txr, rxv, rxd);
    #1;
  endtask

  task automatic idle(input logic ret);
    step(8'h00, 1'b0, 1'b0, 32'd0, ret, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    step(a, 1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_rdata"},    bus.io_rdata,        m_rdata);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid),   32'(m_tx_full));
    chk({tag, "_tx_data"},  32'(bus.tx_data),    32'(m_tx_byte));
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready),   32'(!m_rx_full));
  endtask

  initial begin
    bus4.io_addr = 8'h00; bus4.io_we = 1'b0; bus4.io_re = 1'b0; bus4.io_wdata = 32'd0;
    bus4.instr_retire = 1'b0; bus4.tx_ready = 1'b0; bus4.rx_valid = 1'b0; bus4.rx_data = 8'h00;

    // addr   we    re    wdata          txr   rxv   rxd    e_rdata        e_txv e_txd  e_rxr
    tbl[0]  = '{8'h08, 1'b1, 1'b0, 32'h0000_0041, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
    tbl[1]  = '{8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
    tbl[2]  = '{8'h08, 1'b1, 1'b0, 32'h0000_0042, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
    tbl[3]  = '{8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b1, 8'h41, 1'b1};
    tbl[5]  = '{8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 8'h41, 1'b1};
    tbl[6]  = '{8'h00, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0001, 1'b0, 8'h41, 1'b1};
    tbl[7]  = '{8'h00, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 8'h5A, 32'h0000_0001, 1'b0, 8'h41, 1'b0};
    tbl[8]  = '{8'h04, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 8'h77, 32'h0000_0001, 1'b0, 8'h41, 1'b0};
    tbl[9]  = '{8'h0C, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_005A, 1'b0, 8'h41, 1'b1};
    tbl[10] = '{8'h0C, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_005A, 1'b0, 8'h41, 1'b1};
    tbl[11] = '{8'h08, 1'b1, 1'b0, 32'h1234_5699, 1'b0, 1'b0, 8'h00, 32'h0000_005A, 1'b1, 8'h99, 1'b1};
    tbl[12] = '{8'h08, 1'b1, 1'b1, 32'h0000_00AB, 1'b1, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 8'h99, 1'b1};
    tbl[13] = '{8'h1F, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 8'h99, 1'b1};
    tbl[14] = '{8'h09, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 1'b0, 8'h99, 1'b1};
    tbl[15] = '{8'h00, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_0001, 1'b0, 8'h99, 1'b1};
    tbl[16] = '{8'h0C, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 8'h3C, 32'h0000_005A, 1'b0, 8'h99, 1'b0};
    tbl[17] = '{8'h0C, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 8'h00, 32'h0000_003C, 1'b0, 8'h99, 1'b1};

    // Reset state
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    chk("reset_rdata",    bus.io_rdata,       32'd0);
    chk("reset_tx_valid", 32'(bus.tx_valid),  32'd0);
    chk("reset_tx_data",  32'(bus.tx_data),   32'd0);
    chk("reset_rx_ready", 32'(bus.rx_ready),  32'd1);
    rst = 1'b0;

    // Directed TX/RX vector table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].addr, tbl[i].we, tbl[i].re, tbl[i].wdata, 1'b0,
           tbl[i].txr, tbl[i].rxv, tbl[i].rxd);
      chk($sformatf("vec%0d_rdata", i),    bus.io_rdata,      tbl[i].e_rdata);
      chk($sformatf("vec%0d_tx_valid", i), 32'(bus.tx_valid), 32'(tbl[i].e_txv));
      chk($sformatf("vec%0d_tx_data", i),  32'(bus.tx_data),  32'(tbl[i].e_txd));
      chk($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'(tbl[i].e_rxr));
    end

    // Counters: 10 cycles with 4 retires after reset, then clear
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) idle((i % 3) == 0);
    rd(8'h10);
    chk("cycle_cnt_10", bus.io_rdata, 32'd10);
    rd(8'h14);
    chk("instr_cnt_4", bus.io_rdata, 32'd4);
    step(8'h18, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 8'h00);
    rd(8'h10);
    chk("cycle_cnt_cleared", bus.io_rdata, 32'd0);
    rd(8'h14);
    chk("instr_cnt_cleared", bus.io_rdata, 32'd0);
    rd(8'h10);
    chk("cycle_cnt_resumed", bus.io_rdata, 32'd2);

    // Wrap on the 4-bit counter instance
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) idle(1'b0);
    bus4.io_addr = 8'h10; bus4.io_re = 1'b1;
    idle(1'b0);
    bus4.io_re = 1'b0;
    chk("wrap_cnt4_cycle", bus4.io_rdata, 32'd1);

    // Reset mid-operation with TX and RX both full
    step(8'h08, 1'b1, 1'b0, 32'h0000_00C3, 1'b1, 1'b0, 1'b1, 8'hE7);
    rd(8'h0C);
    step(8'h00, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'h11);
    chk("midop_tx_full", 32'(bus.tx_valid), 32'd1);
    chk("midop_rx_full", 32'(bus.rx_ready), 32'd0);
    chk("midop_rdata",   bus.io_rdata,      32'h0000_00E7);
    rst = 1'b1;
    step(8'h08, 1'b1, 1'b1, 32'h0000_0055, 1'b1, 1'b1, 1'b1, 8'h22);
    rst = 1'b0;
    chk("rst_midop_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_midop_tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst_midop_rx_ready", 32'(bus.rx_ready), 32'd1);
    chk("rst_midop_rdata",    bus.io_rdata,      32'd0);
    rd(8'h10);
    chk("rst_midop_cycle", bus.io_rdata, 32'd0);
    rd(8'h14);
    chk("rst_midop_instr", bus.io_rdata, 32'd0);

    // Randomized run against the behavioural model
    for (int i = 0; i < 600; i++) begin
      logic [7:0] a;
      a = {1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      a = {a[7:5] & 3'b000, a[4:0]};
      step(a, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), 8'($urandom));
      chk_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
